// File: rtl/calc_mp_core_if.sv
// Request/response bundle for calc_mp_core: per-port command and data in,
// per-port response code and result out.
interface calc_mp_core_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0][3:0]        req_cmd_in;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_data_in;
  logic [NUM_PORTS-1:0][1:0]        out_resp;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_data;

  modport master (
    output req_cmd_in,
    output req_data_in,
    input  out_resp,
    input  out_data
  );

  modport slave (
    input  req_cmd_in,
    input  req_data_in,
    output out_resp,
    output out_data
  );
endinterface

// File: rtl/calc_mp_core.sv
// Multi-port calculator: each port collects a command and two operands, then a
// shared round-robin arbiter feeds one pending request per cycle to a single ALU.
module calc_mp_core #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input  logic          c_clk,
  input  logic          reset,
  calc_mp_core_if.slave bus
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OP2  = 2'b01;
  localparam logic [1:0] ST_PEND = 2'b10;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_SHL = 4'b0101;
  localparam logic [3:0] CMD_SHR = 4'b0110;

  localparam logic [1:0] RESP_OK  = 2'b01;
  localparam logic [1:0] RESP_ERR = 2'b10;

  localparam logic [DATA_W-1:0] DW_VAL = DATA_W'(DATA_W);

  logic [NUM_PORTS-1:0][1:0]        state_r;
  logic [NUM_PORTS-1:0][3:0]        cmd_r;
  logic [NUM_PORTS-1:0][DATA_W-1:0] op1_r;
  logic [NUM_PORTS-1:0][DATA_W-1:0] op2_r;
  logic [NUM_PORTS-1:0][1:0]        resp_r;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_r;

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic             gnt_vld_r;

  logic [NUM_PORTS-1:0] elig_s;
  logic [IDX_W-1:0]     gnt_idx_s;
  logic                 gnt_vld_s;
  logic [IDX_W:0]       cand_s;
  logic [IDX_W:0]       ptr_nxt_s;

  logic [3:0]        exe_cmd_s;
  logic [DATA_W-1:0] exe_op1_s;
  logic [DATA_W-1:0] exe_op2_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] shamt_s;
  logic [1:0]        exe_resp_s;
  logic [DATA_W-1:0] exe_data_s;

  // Eligibility: a port already in its execute cycle must not be granted twice
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig_s[p] = (state_r[p] == ST_PEND) && !(gnt_vld_r && (gnt_idx_r == IDX_W'(p)));
    end
  end

  // Round-robin search starting at the pointer, plus the pointer's next value
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    cand_s    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_s = {1'b0, ptr_r} + (IDX_W+1)'(i);
      if (cand_s >= (IDX_W+1)'(NUM_PORTS)) begin
        cand_s = cand_s - (IDX_W+1)'(NUM_PORTS);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_vld_s && elig_s[cand_s[IDX_W-1:0]]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = cand_s[IDX_W-1:0];
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    ptr_nxt_s = {1'b0, gnt_idx_s} + (IDX_W+1)'(1);
    if (ptr_nxt_s >= (IDX_W+1)'(NUM_PORTS)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = ptr_nxt_s;
    end
  end

  // Single-cycle ALU on the request granted in the previous cycle
  always_comb begin
    exe_cmd_s  = cmd_r[gnt_idx_r];
    exe_op1_s  = op1_r[gnt_idx_r];
    exe_op2_s  = op2_r[gnt_idx_r];
    sum_s      = {1'b0, exe_op1_s} + {1'b0, exe_op2_s};
    shamt_s    = exe_op2_s % DW_VAL;
    exe_resp_s = RESP_ERR;
    exe_data_s = '0;
    case (exe_cmd_s)
      CMD_ADD: begin
        if (sum_s[DATA_W]) begin
          exe_resp_s = RESP_ERR;
          exe_data_s = '0;
        end else begin
          exe_resp_s = RESP_OK;
          exe_data_s = sum_s[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (exe_op2_s > exe_op1_s) begin
          exe_resp_s = RESP_ERR;
          exe_data_s = '0;
        end else begin
          exe_resp_s = RESP_OK;
          exe_data_s = exe_op1_s - exe_op2_s;
        end
      end
      CMD_SHL: begin
        exe_resp_s = RESP_OK;
        exe_data_s = exe_op1_s << shamt_s;
      end
      CMD_SHR: begin
        exe_resp_s = RESP_OK;
        exe_data_s = exe_op1_s >> shamt_s;
      end
      default: begin
        exe_resp_s = RESP_ERR;
        exe_data_s = '0;
      end
    endcase
  end

  // Per-port request FSMs; a port leaves PEND as its result is registered
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_r <= '0;
      cmd_r   <= '0;
      op1_r   <= '0;
      op2_r   <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case (state_r[p])
          ST_IDLE: begin
            if (bus.req_cmd_in[p] != CMD_NOP) begin
              state_r[p] <= ST_OP2;
              cmd_r[p]   <= bus.req_cmd_in[p];
              op1_r[p]   <= bus.req_data_in[p];
            end
          end
          ST_OP2: begin
            state_r[p] <= ST_PEND;
            op2_r[p]   <= bus.req_data_in[p];
          end
          ST_PEND: begin
            if (gnt_vld_r && (gnt_idx_r == IDX_W'(p))) begin
              state_r[p] <= ST_IDLE;
            end
          end
          default: state_r[p] <= ST_IDLE;
        endcase
      end
    end
  end

  // Grant register and round-robin pointer
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      gnt_vld_r <= 1'b0;
      gnt_idx_r <= '0;
      ptr_r     <= '0;
    end else begin
      gnt_vld_r <= gnt_vld_s;
      gnt_idx_r <= gnt_idx_s;
      if (gnt_vld_s) begin
        ptr_r <= ptr_nxt_s[IDX_W-1:0];
      end
    end
  end

  // One-cycle response pulse on the executed port; all other ports read zero
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      resp_r <= '0;
      data_r <= '0;
    end else begin
      resp_r <= '0;
      data_r <= '0;
      if (gnt_vld_r) begin
        resp_r[gnt_idx_r] <= exe_resp_s;
        data_r[gnt_idx_r] <= exe_data_s;
      end
    end
  end

  assign bus.out_resp = resp_r;
  assign bus.out_data = data_r;

endmodule
